rr_grant_scheduler: RTL

//   Round-robin scheduler that shares one resource among NUM_REQUESTERS

---
 rtl/rr_grant_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_scheduler (with idx_to_oh helper)
// Brief    : Round-robin grant scheduler with hold limit and one-hot select.
// Revision : 1.0
// ============================================================================

module idx_to_oh #(
    parameter int    N         = 4,
    parameter int    WIDTH     = 2,
    parameter string DIRECTION = "LSB0"
) (
    input  logic [WIDTH-1:0] i_idx,
    output logic [N-1:0]     o_oh
);
    // MSB0 mirrors the vector so index 0 lands on the top bit
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        if (DIRECTION == "MSB0") begin : g_msb0
            assign o_oh[gi] = (i_idx == WIDTH'(N - 1 - gi));
        end else begin : g_lsb0
            assign o_oh[gi] = (i_idx == WIDTH'(gi));
        end
    end
endmodule

module rr_grant_scheduler #(
    parameter int    NUM_REQUESTERS = 4,
    parameter int    MAX_HOLD       = 16,
    parameter string DIRECTION      = "LSB0",
    parameter int    INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      release_grant,
    output logic                      grant_valid,
    output logic [INDEX_WIDTH-1:0]    grant_idx,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic                      grant_timeout
);
    localparam int                     c_HOLD_WIDTH = $clog2(MAX_HOLD);
    localparam logic [0:0]             c_IDLE       = 1'b0;
    localparam logic [0:0]             c_GRANT      = 1'b1;
    localparam logic [INDEX_WIDTH-1:0] c_LAST_IDX   = INDEX_WIDTH'(NUM_REQUESTERS - 1);
    localparam logic [c_HOLD_WIDTH-1:0] c_HOLD_LIMIT = c_HOLD_WIDTH'(MAX_HOLD - 1);

    logic [0:0]                r_state;
    logic [INDEX_WIDTH-1:0]    r_ptr;
    logic [c_HOLD_WIDTH-1:0]   r_hold;
    logic [INDEX_WIDTH-1:0]    r_idx;
    logic                      r_valid;
    logic [NUM_REQUESTERS-1:0] r_oh;
    logic                      r_timeout;

    logic [0:0]                w_state_nxt;
    logic [INDEX_WIDTH-1:0]    w_ptr_nxt;
    logic [c_HOLD_WIDTH-1:0]   w_hold_nxt;
    logic [INDEX_WIDTH-1:0]    w_idx_nxt;
    logic                      w_valid_nxt;
    logic                      w_timeout_nxt;
    logic [NUM_REQUESTERS-1:0] w_oh_nxt;
    logic [INDEX_WIDTH-1:0]    w_pick;
    logic                      w_found;
    logic [INDEX_WIDTH-1:0]    w_ptr_inc;

    // Modulo-N add; N need not be a power of two so wrap explicitly
    function automatic logic [INDEX_WIDTH-1:0] wrap_add(input logic [INDEX_WIDTH-1:0] base,
                                                        input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
        return INDEX_WIDTH'(sum);
    endfunction

    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!w_found && request[wrap_add(r_ptr, i)]) begin
                w_pick  = wrap_add(r_ptr, i);
                w_found = 1'b1;
            end
        end
    end

    assign w_ptr_inc = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_oh      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_oh      <= w_valid_nxt ? w_oh_nxt : '0;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_idx_nxt     = r_idx;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_GRANT;
                    w_idx_nxt   = w_pick;
                    w_hold_nxt  = '0;
                end
            end
            c_GRANT: begin
                w_hold_nxt = r_hold + 1'b1;
                // An explicit release on the limit cycle is not a timeout
                if (release_grant || (r_hold == c_HOLD_LIMIT)) begin
                    w_state_nxt   = c_IDLE;
                    w_ptr_nxt     = w_ptr_inc;
                    w_hold_nxt    = '0;
                    w_timeout_nxt = !release_grant;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign w_valid_nxt = (w_state_nxt == c_GRANT);

    idx_to_oh #(
        .N         (NUM_REQUESTERS),
        .WIDTH     (INDEX_WIDTH),
        .DIRECTION (DIRECTION)
    ) u_idx_to_oh (
        .i_idx (w_idx_nxt),
        .o_oh  (w_oh_nxt)
    );

    always_comb begin
        grant_valid   = r_valid;
        grant_idx     = r_idx;
        grant_oh      = r_oh;
        grant_timeout = r_timeout;
    end
endmodule

`default_nettype wire
